// File: rtl/fp_mul_if.sv
// Request/response bundle for fp_mul_core: operands and sideband in, unrounded product and flags out.
interface fp_mul_if;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mode_fp;
    logic        round_mode;
    logic [4:0]  initial_flags;
    logic        start;
    logic        ready_in;
    logic        valid_out;
    logic        ready_out;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [26:0] mant_out;
    logic [4:0]  flags;
    logic        mode_fp_out;

    modport master (
        output op_a, op_b, mode_fp, round_mode, initial_flags, start, ready_in,
        input  valid_out, ready_out, sign_out, exp_out, mant_out, flags, mode_fp_out
    );

    modport slave (
        input  op_a, op_b, mode_fp, round_mode, initial_flags, start, ready_in,
        output valid_out, ready_out, sign_out, exp_out, mant_out, flags, mode_fp_out
    );
endinterface

// File: rtl/fp_mul_core.sv
// Multi-cycle binary32 multiplier producing an unrounded {hidden, frac, G, R, S} result plus flags.
// Optional FP_MUL_DAZ_EN: subnormal inputs are treated as signed zero (no pre-normalization).
module fp_mul_core #(
    parameter int unsigned EXP  = 8,
    parameter int unsigned FRAC = 23,
    parameter int unsigned BIAS = 127
) (
    input logic     clk,
    input logic     rst_n,
    fp_mul_if.slave bus
);
    localparam int unsigned W   = 1 + EXP + FRAC;
    localparam int unsigned MW  = FRAC + 1;
    localparam int unsigned PW  = 2 * MW;
    localparam int unsigned EW  = EXP + 3;
    localparam int unsigned OW  = MW + 3;
    localparam int unsigned FLW = 5;
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d;
    logic                   mode_q, mode_d, rm_q, rm_d;
    logic [FLW-1:0]         ifl_q, ifl_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic signed [EW-1:0]   esum_q, esum_d;
    logic                   sign_q, sign_d, valid_q, valid_d, ready_q, ready_d;
    logic [EXP-1:0]         exp_q, exp_d;
    logic [OW-1:0]          mant_q, mant_d;
    logic [FLW-1:0]         flags_q, flags_d;

`ifndef FP_MUL_DAZ_EN
    localparam int unsigned LZW = $clog2(MW + 1);

    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] m);
        logic found;
        lzc   = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      lzc   = lzc + LZW'(1);
            end
        end
    endfunction
`endif

    // Significand with hidden bit at MSB and biased exponent; subnormals are left-justified.
    function automatic void unpack(input logic [W-1:0] x, output logic [MW-1:0] m,
                                   output logic signed [EW-1:0] e);
        logic [EXP-1:0]  ef;
        logic [FRAC-1:0] ff;
        ef = x[W-2:FRAC];
        ff = x[FRAC-1:0];
        if (|ef) begin
            m = {1'b1, ff};
            e = EW'(ef);
        end else begin
`ifdef FP_MUL_DAZ_EN
            m = '0;
            e = '0;
`else
            m = {1'b0, ff} << lzc({1'b0, ff});
            e = EW'(1) - EW'(lzc({1'b0, ff}));
`endif
        end
    endfunction

    function automatic void classify(input logic [W-1:0] x, output logic nan, output logic snan,
                                     output logic inf, output logic zero);
        logic [EXP-1:0]  ef;
        logic [FRAC-1:0] ff;
        ef   = x[W-2:FRAC];
        ff   = x[FRAC-1:0];
        nan  = (&ef) && (|ff);
        snan = nan && !ff[FRAC-1];
        inf  = (&ef) && !(|ff);
`ifdef FP_MUL_DAZ_EN
        zero = ~|ef;
`else
        zero = ~|ef && ~|ff;
`endif
    endfunction

    logic [MW-1:0]        ma, mb, top;
    logic signed [EW-1:0] ea, eb, e_n;
    logic                 a_nan, a_snan, a_inf, a_zero, b_nan, b_snan, b_inf, b_zero;
    logic                 renorm, g, r, s, inv_zero;
    logic                 res_sign;
    logic [EXP-1:0]       res_exp;
    logic [OW-1:0]        res_mant;
    logic [FLW-1:0]       res_flags;

    // Result datapath: unpack in MUL, normalize and resolve specials in NORM.
    always_comb begin
        unpack(a_q, ma, ea);
        unpack(b_q, mb, eb);
        classify(a_q, a_nan, a_snan, a_inf, a_zero);
        classify(b_q, b_nan, b_snan, b_inf, b_zero);

        renorm   = prod_q[PW-1];
        top      = renorm ? prod_q[PW-1 -: MW] : prod_q[PW-2 -: MW];
        g        = renorm ? prod_q[PW-MW-1] : prod_q[PW-MW-2];
        r        = renorm ? prod_q[PW-MW-2] : prod_q[PW-MW-3];
        s        = renorm ? |prod_q[PW-MW-3:0] : |prod_q[PW-MW-4:0];
        e_n      = esum_q + EW'(renorm);
        inv_zero = (a_inf && b_zero) || (b_inf && a_zero);

        res_sign  = a_q[W-1] ^ b_q[W-1];
        res_exp   = '0;
        res_mant  = '0;
        res_flags = '0;
        if (a_nan || b_nan || inv_zero) begin
            res_sign     = 1'b0;
            res_exp      = '1;
            res_mant     = {2'b11, (OW-2)'(0)};
            res_flags[4] = a_snan || b_snan || inv_zero;
        end else if (a_inf || b_inf) begin
            res_exp = '1;
        end else if (a_zero || b_zero) begin
            res_exp = '0;
        end else if (e_n >= EMAX) begin
            res_flags = 5'b00101;
            if (rm_q) begin
                res_exp  = {{(EXP-1){1'b1}}, 1'b0};
                res_mant = {{MW{1'b1}}, 3'b000};
            end else begin
                res_exp = '1;
            end
        end else if (e_n <= EZERO) begin
            res_flags = 5'b00011;
        end else begin
            res_exp      = e_n[EXP-1:0];
            res_mant     = {top, g, r, s};
            res_flags[0] = g | r | s;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        rm_d    = rm_q;
        ifl_d   = ifl_q;
        prod_d  = prod_q;
        esum_d  = esum_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        flags_d = flags_q;
        valid_d = valid_q;
        ready_d = ready_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                a_d     = bus.op_a;
                b_d     = bus.op_b;
                mode_d  = bus.mode_fp;
                rm_d    = bus.round_mode;
                ifl_d   = bus.initial_flags;
                ready_d = 1'b0;
                state_d = S_MUL;
            end
            S_MUL: begin
                prod_d  = PW'(ma) * PW'(mb);
                esum_d  = ea + eb - EW'(BIAS);
                state_d = S_NORM;
            end
            S_NORM: begin
                sign_d  = res_sign;
                exp_d   = res_exp;
                mant_d  = res_mant;
                flags_d = res_flags | ifl_q;
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: if (bus.ready_in) begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            rm_q    <= 1'b0;
            ifl_q   <= '0;
            prod_q  <= '0;
            esum_q  <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            rm_q    <= rm_d;
            ifl_q   <= ifl_d;
            prod_q  <= prod_d;
            esum_q  <= esum_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.valid_out   = valid_q;
    assign bus.ready_out   = ready_q;
    assign bus.sign_out    = sign_q;
    assign bus.exp_out     = exp_q;
    assign bus.mant_out    = mant_q;
    assign bus.flags       = flags_q;
    assign bus.mode_fp_out = mode_q;
endmodule

// File: tb/tb_fp_mul_core.sv
// Directed and random checks of fp_mul_core against an exact-arithmetic reference model.
module tb_fp_mul_core;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    fp_mul_if bus ();
    fp_mul_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] x, output longint m, output int e,
                                   output bit nan, output bit snan, output bit inf, output bit zero);
        int ex;
        ex   = int'(x[30:23]);
        nan  = (ex == 255) && (x[22:0] != 0);
        snan = nan && !x[22];
        inf  = (ex == 255) && (x[22:0] == 0);
`ifdef FP_MUL_DAZ_EN
        zero = (ex == 0);
`else
        zero = (ex == 0) && (x[22:0] == 0);
`endif
        if (ex != 0) begin
            m = longint'({1'b1, x[22:0]});
            e = ex - 127;
        end else begin
            m = longint'(x[22:0]);
            e = -126;
        end
    endfunction

    // Exact product value = ma*mb * 2^(ea+eb-46); keep 26 leading bits and a sticky bit.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input logic rm,
                                    input logic [4:0] ifl, output logic s, output logic [7:0] e,
                                    output logic [26:0] m, output logic [4:0] fl);
        longint ma, mb, pv;
        int     ea, eb, p, re;
        bit     an, as, ai, az, bn, bs, bi, bz, st;
        logic [25:0] top;
        decode(a, ma, ea, an, as, ai, az);
        decode(b, mb, eb, bn, bs, bi, bz);
        s  = a[31] ^ b[31];
        e  = 8'h00;
        m  = 27'h0;
        fl = 5'b0;
        if (an || bn || (ai && bz) || (bi && az)) begin
            s     = 1'b0;
            e     = 8'hFF;
            m     = 27'h6000000;
            fl[4] = as || bs || (ai && bz) || (bi && az);
        end else if (ai || bi) begin
            e = 8'hFF;
        end else if (!(az || bz)) begin
            pv = ma * mb;
            p  = 0;
            for (int i = 0; i < 64; i++) if (pv[i]) p = i;
            re = p - 46 + ea + eb + 127;
            if (p >= 25) begin
                top = 26'(pv >> (p - 25));
                st  = (pv & ((64'd1 << (p - 25)) - 64'd1)) != 0;
            end else begin
                top = 26'(pv << (25 - p));
                st  = 1'b0;
            end
            m = {top, st};
            if (re >= 255) begin
                fl = 5'b00101;
                if (rm) begin e = 8'hFE; m = 27'h7FFFFF8; end
                else    begin e = 8'hFF; m = 27'h0;       end
            end else if (re <= 0) begin
                e  = 8'h00;
                m  = 27'h0;
                fl = 5'b00011;
            end else begin
                e     = 8'(re);
                fl[0] = (m[2:0] != 3'b000);
            end
        end
        fl = fl | ifl;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic       sg;
        logic [7:0] ex;
        logic [22:0] fr;
        int k;
        k  = int'($urandom_range(0, 19));
        sg = 1'($urandom_range(0, 1));
        fr = 23'($urandom);
        case (k)
            0:       begin ex = 8'h00; fr = 23'h0; end
            1:       ex = 8'h00;
            2:       begin ex = 8'hFF; fr = 23'h0; end
            3:       begin ex = 8'hFF; fr = fr | 23'h1; end
            4, 5:    ex = 8'($urandom_range(1, 254));
            default: ex = 8'($urandom_range(87, 167));
        endcase
        return {sg, ex, fr};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic rm,
                            input logic md, input logic [4:0] ifl);
        @(negedge clk);
        check("ready_before_accept", 32'(bus.ready_out), 32'd1);
        bus.op_a          = a;
        bus.op_b          = b;
        bus.round_mode    = rm;
        bus.mode_fp       = md;
        bus.initial_flags = ifl;
        bus.start         = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_valid();
        @(posedge clk);
        #1 check("valid_low_edge2", 32'(bus.valid_out), 32'd0);
        @(posedge clk);
        #1 check("valid_high_edge3", 32'(bus.valid_out), 32'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.ready_in = 1'b1;
        @(posedge clk);
        #1 bus.ready_in = 1'b0;
        check("ready_after_consume", 32'(bus.ready_out), 32'd1);
        check("valid_after_consume", 32'(bus.valid_out), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic rm, input logic md, input logic [4:0] ifl,
                            input logic xs, input logic [7:0] xe, input logic [26:0] xm,
                            input logic [4:0] xf);
        start_op(a, b, rm, md, ifl);
        wait_valid();
        check({tag, "_sign"}, 32'(bus.sign_out), 32'(xs));
        check({tag, "_exp"}, 32'(bus.exp_out), 32'(xe));
        check({tag, "_mant"}, 32'(bus.mant_out), 32'(xm));
        check({tag, "_flags"}, 32'(bus.flags), 32'(xf));
        check({tag, "_mode"}, 32'(bus.mode_fp_out), 32'(md));
        consume();
    endtask

    logic        xs;
    logic [7:0]  xe;
    logic [26:0] xm, held_m;
    logic [4:0]  xf;
    logic [31:0] ra, rb;
    logic        rrm, rmd;
    logic [4:0]  rifl;

    initial begin
        bus.op_a = '0; bus.op_b = '0; bus.mode_fp = 1'b0; bus.round_mode = 1'b0;
        bus.initial_flags = '0; bus.start = 1'b0; bus.ready_in = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready_out), 32'd1);
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_exp", 32'(bus.exp_out), 32'd0);
        check("rst_mant", 32'(bus.mant_out), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        @(negedge clk) rst_n = 1'b0;

        directed("d_1p5x2", 32'h3FC00000, 32'h40000000, 1'b0, 1'b0, 5'b0, 1'b0, 8'h80, 27'h6000000, 5'b00000);
        directed("d_ulp", 32'h3F800001, 32'h3F800001, 1'b0, 1'b0, 5'b0, 1'b0, 8'h7F, 27'h4000011, 5'b00001);
        directed("d_infx0", 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 5'b0, 1'b0, 8'hFF, 27'h6000000, 5'b10000);
        directed("d_ovf_rne", 32'h7F000000, 32'h7F000000, 1'b0, 1'b0, 5'b0, 1'b0, 8'hFF, 27'h0, 5'b00101);
        directed("d_ovf_rtz", 32'h7F000000, 32'h7F000000, 1'b1, 1'b0, 5'b0, 1'b0, 8'hFE, 27'h7FFFFF8, 5'b00101);
        directed("d_pass", 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 5'b01000, 1'b0, 8'h7F, 27'h4000000, 5'b01000);
        directed("d_negzero", 32'h80000000, 32'h3F800000, 1'b0, 1'b0, 5'b0, 1'b1, 8'h00, 27'h0, 5'b00000);

        // Backpressure: outputs frozen in DONE, a stray start is ignored.
        start_op(32'h3FC00000, 32'h40000000, 1'b0, 1'b0, 5'b0);
        wait_valid();
        held_m = bus.mant_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.op_a  = 32'h40400000;
            bus.start = (i == 2);
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.valid_out), 32'd1);
            check("bp_ready", 32'(bus.ready_out), 32'd0);
            check("bp_mant", 32'(bus.mant_out), 32'(held_m));
            check("bp_exp", 32'(bus.exp_out), 32'h80);
        end
        @(negedge clk) bus.start = 1'b0;
        consume();

        // Reset asserted while in MUL.
        start_op(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 5'b0);
        rst_n = 1'b1;
        #1;
        check("rst_mul_ready", 32'(bus.ready_out), 32'd1);
        check("rst_mul_valid", 32'(bus.valid_out), 32'd0);
        check("rst_mul_exp", 32'(bus.exp_out), 32'd0);
        check("rst_mul_mode", 32'(bus.mode_fp_out), 32'd0);
        @(negedge clk) rst_n = 1'b0;

        for (int n = 0; n < 60; n++) begin
            ra   = rand_fp();
            rb   = rand_fp();
            rrm  = 1'($urandom_range(0, 1));
            rmd  = 1'($urandom_range(0, 1));
            rifl = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            ref_mul(ra, rb, rrm, rifl, xs, xe, xm, xf);
            start_op(ra, rb, rrm, rmd, rifl);
            wait_valid();
            check("rnd_sign", 32'(bus.sign_out), 32'(xs));
            check("rnd_exp", 32'(bus.exp_out), 32'(xe));
            check("rnd_mant", 32'(bus.mant_out), 32'(xm));
            check("rnd_flags", 32'(bus.flags), 32'(xf));
            check("rnd_mode", 32'(bus.mode_fp_out), 32'(rmd));
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
